// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2R1W register file with registered reads, post-reset clear sequencer, optional bypass and zero entry
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            re,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    input  logic            reg_wr,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wda,
    output logic [XLEN-1:0] rda,
    output logic [XLEN-1:0] rdb,
    output logic            rvalid,
    output logic            ready
);
    localparam logic [0:0]    CLEAR = 1'b0;
    localparam logic [0:0]    RUN   = 1'b1;
    localparam logic [AW:0]   NR    = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] rda_q, rda_d, rdb_q, rdb_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic            run, wr_ok, ra_ok, rb_ok, ra_hit, rb_hit;
    assign run    = state_q == RUN;
    assign wr_ok  = run && reg_wr && ({1'b0, wa} < NR) && !(ZERO_REG != 0 && wa == '0);
    assign ra_ok  = ({1'b0, ra} < NR) && !(ZERO_REG != 0 && ra == '0);
    assign rb_ok  = ({1'b0, rb} < NR) && !(ZERO_REG != 0 && rb == '0);
    assign ra_hit = BYPASS != 0 && wr_ok && wa == ra;
    assign rb_hit = BYPASS != 0 && wr_ok && wa == rb;
    always_comb begin
        state_d  = run ? RUN : (idx_q == LAST ? RUN : CLEAR);
        idx_d    = run ? idx_q : idx_q + AW'(1);
        rvalid_d = run && re;
        rda_d    = !run ? '0 : !re ? rda_q : !ra_ok ? '0 : ra_hit ? wda : mem_q[ra];
        rdb_d    = !run ? '0 : !re ? rdb_q : !rb_ok ? '0 : rb_hit ? wda : mem_q[rb];
        mem_d    = mem_q;
        if (!run)
            mem_d[idx_q] = '0;
        else if (wr_ok)
            mem_d[wa] = wda;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= CLEAR;
            idx_q    <= '0;
            rda_q    <= '0;
            rdb_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rda_q    <= rda_d;
            rdb_q    <= rdb_d;
            rvalid_q <= rvalid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (reset)
            mem_q <= mem_d;
    end
    assign rda    = rda_q;
    assign rdb    = rdb_q;
    assign rvalid = rvalid_q;
    assign ready  = run;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: three configurations driven in lockstep and checked against an array-based reference model
module tb_reg_file_param;
    logic        clk = 1'b0;
    logic        reset, re, reg_wr;
    logic [4:0]  ra, rb, wa;
    logic [31:0] wda;
    logic [31:0] rda_o [3];
    logic [31:0] rdb_o [3];
    logic        rv_o  [3];
    logic        rdy_o [3];
    int          pn [3] = '{32, 32, 20};
    bit          pz [3] = '{1, 1, 0};
    bit          pb [3] = '{1, 0, 1};
    logic [31:0] mmem [3][32];
    int          cnt  [3];
    logic [31:0] erda [3];
    logic [31:0] erdb [3];
    logic        erv  [3];
    int          n_chk = 0;
    int          n_fail = 0;
    string       phase = "init";
    always #5 clk = ~clk;
    reg_file_param #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .re(re), .ra(ra), .rb(rb), .reg_wr(reg_wr), .wa(wa), .wda(wda),
        .rda(rda_o[0]), .rdb(rdb_o[0]), .rvalid(rv_o[0]), .ready(rdy_o[0]));
    reg_file_param #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .re(re), .ra(ra), .rb(rb), .reg_wr(reg_wr), .wa(wa), .wda(wda),
        .rda(rda_o[1]), .rdb(rdb_o[1]), .rvalid(rv_o[1]), .ready(rdy_o[1]));
    reg_file_param #(.XLEN(32), .NREGS(20), .ZERO_REG(0), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .re(re), .ra(ra), .rb(rb), .reg_wr(reg_wr), .wa(wa), .wda(wda),
        .rda(rda_o[2]), .rdb(rdb_o[2]), .rvalid(rv_o[2]), .ready(rdy_o[2]));
    function automatic bit legal(int i, logic w, logic [4:0] a);
        return w && int'(a) < pn[i] && !(pz[i] && a == 0);
    endfunction
    function automatic logic [31:0] fread(int i, logic [4:0] a, logic w, logic [4:0] wad, logic [31:0] wd);
        if (int'(a) >= pn[i]) return 32'h0;
        if (pz[i] && a == 0) return 32'h0;
        if (pb[i] && legal(i, w, wad) && wad == a) return wd;
        return mmem[i][a];
    endfunction
    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s[u%0d] observed=%h expected=%h", phase, tag, i, obs, exp);
        end
    endtask
    task automatic step(logic rst_n, logic r_e, logic [4:0] a, logic [4:0] b,
                        logic w, logic [4:0] wad, logic [31:0] wd);
        reset = rst_n; re = r_e; ra = a; rb = b; reg_wr = w; wa = wad; wda = wd;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                cnt[i] = 0; erda[i] = 0; erdb[i] = 0; erv[i] = 0;
            end else if (cnt[i] < pn[i]) begin
                mmem[i][cnt[i]] = 0; cnt[i]++; erv[i] = 0; erda[i] = 0; erdb[i] = 0;
            end else begin
                erv[i] = r_e;
                if (r_e) begin
                    erda[i] = fread(i, a, w, wad, wd);
                    erdb[i] = fread(i, b, w, wad, wd);
                end
                if (legal(i, w, wad)) mmem[i][wad] = wd;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, {31'b0, rdy_o[i]}, {31'b0, cnt[i] >= pn[i]});
            chk("rvalid", i, {31'b0, rv_o[i]}, {31'b0, erv[i]});
            chk("rda", i, rda_o[i], erda[i]);
            chk("rdb", i, rdb_o[i], erdb[i]);
        end
    endtask
    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rand_traffic(int n);
        for (int k = 0; k < n; k++)
            step(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), $urandom);
    endtask
    initial begin
        phase = "reset";
        for (int k = 0; k < 3; k++) step(0, 1, 5, 31, 1, 4, 32'hFFFF_FFFF);
        phase = "clear";
        for (int k = 0; k < 32; k++) step(1, 1, 5, 31, 1'($urandom), 5'($urandom), $urandom);
        phase = "zeroed";
        for (int k = 0; k < 32; k++) step(1, 1, 5'(k), 5'(31 - k), 0, 0, 0);
        phase = "basic";
        step(1, 0, 0, 0, 1, 7, 32'hDEAD_BEEF);
        step(1, 1, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 32'h1234);
        step(1, 1, 0, 0, 0, 0, 0);
        phase = "bypass";
        step(1, 0, 0, 0, 1, 3, 32'h11);
        step(1, 1, 3, 3, 1, 3, 32'hA5A5_A5A5);
        step(1, 1, 3, 7, 0, 0, 0);
        phase = "range";
        step(1, 0, 0, 0, 1, 25, 32'hCAFE_0025);
        step(1, 1, 25, 19, 0, 0, 0);
        step(1, 0, 0, 0, 1, 19, 32'hCAFE_0019);
        step(1, 1, 19, 25, 0, 0, 0);
        for (int k = 0; k < 32; k++) step(1, 1, 5'(k), 5'(k), 0, 0, 0);
        phase = "random";
        rand_traffic(300);
        phase = "stream";
        for (int k = 1; k <= 8; k++) step(1, 0, 0, 0, 1, 5'(k), 32'h5000_0000 + 32'(k * 17));
        for (int k = 1; k <= 8; k++) step(1, 1, 5'(k), 5'(9 - k), 0, 0, 0);
        idle(3);
        phase = "refill";
        for (int k = 1; k < 32; k++) step(1, 0, 0, 0, 1, 5'(k), 32'h7700_0000 + 32'(k));
        step(0, 1, 1, 2, 1, 5, 32'h1);
        step(0, 1, 1, 2, 0, 0, 0);
        phase = "reclear";
        for (int k = 0; k < 10; k++) step(1, 1, 1, 2, 1, 5'(k + 1), 32'hBAD0_0000);
        step(0, 1, 3, 4, 1, 3, 32'h2);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) step(1, 1, 5'(k), 5'(31 - k), 1, 5'(k), 32'hBAD1_0000);
        phase = "after_reclear";
        for (int k = 0; k < 32; k++) step(1, 1, 5'(k), 5'(31 - k), 0, 0, 0);
        phase = "random2";
        rand_traffic(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the core integer register file: configurable data width and depth, two read ports, one write port.
- Read ports are registered (1-cycle latency) with a valid strobe.
- Optional write-to-read bypass and optional hardwired-zero entry 0.
- After reset, an internal clear sequencer zeroes every entry before the file accepts traffic; sits between decode (reads) and writeback (writes) in the core pipeline.

Parameters:
- XLEN, 32, data width of each entry.
- NREGS, 32, number of entries (≥2, need not be a power of 2); address width AW = clog2(NREGS).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read; 0 = read returns pre-write contents.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = in reset).
- re  input  1  read enable; samples ra/rb this cycle.
- ra  input  AW  read address, port A.
- rb  input  AW  read address, port B.
- reg_wr  input  1  write enable.
- wa  input  AW  write address.
- wda  input  XLEN  write data.
- rda  output  XLEN  registered read data, port A.
- rdb  output  XLEN  registered read data, port B.
- rvalid  output  1  rda/rdb hold the result of a read accepted the previous cycle.
- ready  output  1  clear complete; reads and writes are accepted.

Behaviour:
- Reset (reset=0 at a clk edge):
  - rda=0, rdb=0, rvalid=0, ready=0.
  - Clear index is set to 0 and the FSM goes to CLEAR.
  - Array contents are not otherwise touched during reset.
- FSM states: CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry[idx]; idx increments.
  - When idx = NREGS-1 is written, go to RUN the next cycle.
  - ready=1 exactly in RUN, i.e. it asserts at the NREGS-th rising edge after reset is released.
- In CLEAR:
  - reg_wr and re are ignored; nothing is queued.
  - rvalid=0; rda/rdb hold 0.
- In RUN, write:
  - If reg_wr=1 and wa<NREGS and not (ZERO_REG and wa=0), entry[wa] <= wda at the edge.
  - Otherwise there is no write.
- In RUN, read:
  - If re=1, at the edge rda <= f(ra), rdb <= f(rb), and rvalid <= 1.
  - If re=0, rvalid <= 0 and rda/rdb hold their previous values.
- f(a):
  - 0 if a ≥ NREGS.
  - 0 if ZERO_REG and a=0.
  - Else wda if BYPASS and reg_wr=1 and wa=a (with the write itself legal).
  - Else entry[a] as of before the edge.
- Latency: one cycle from re to rvalid/data; back-to-back reads every cycle; full throughput.
- Simultaneous ra=rb: both ports return identical data.
- Write + read of the same address in the same cycle, BYPASS=0: old value returned; new value visible on the next read.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to reset values. The clear restarts from idx 0 after release; any partially written data is discarded by the clear.
- No X propagation: every output is defined from the first reset edge.

Test Plan:
- Hold reset=0 for 3 cycles, release; NREGS=32 -> ready=0 for 31 cycles, ready=1 on the 32nd edge after release; re=1 with ra=5, rb=31 during CLEAR -> rvalid stays 0; after ready, a read -> rda=rdb=0.
- RUN: write wa=7, wda=0xDEADBEEF; next cycle re=1, ra=7, rb=0 -> one cycle later rvalid=1, rda=0xDEADBEEF, rdb=0. Write wa=0, wda=0x1234 -> a subsequent read of ra=0 returns 0.
- Same-cycle write wa=3, wda=0xA5A5A5A5 with re=1, ra=3, entry[3] previously 0x11 -> BYPASS=1: rda=0xA5A5A5A5; BYPASS=0: rda=0x11, and the following read returns 0xA5A5A5A5.
- NREGS=20 (AW=5): write wa=25 then read ra=25 -> rda=0; entries 0..19 unchanged; write/read of wa=19 works normally.
- Fill entries 1..31 with distinct values, assert reset=0 at cycle 10 of a later re-clear, release -> ready re-asserts 32 cycles after release; all reads return 0; rvalid=0 throughout reset.
- Continuous re=1 for 8 cycles with ra stepping 1..8 -> rvalid=1 every cycle from the 2nd; rda sequence matches the stored values with exactly one-cycle lag; re=0 -> rvalid drops next edge while rda holds its last value.
